// File: rtl/mips_ls_pkg.sv
// rtl/mips_ls_pkg.sv - opcodes, FSM states and size_sel encodings for the load/store sequencer
// Optional MIPS_LS_PERF_EN adds the retire/stall counters.
package mips_ls_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LUI = 6'h0F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ADDR   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  // {select2,select1,select0} seen by the byte/half extension units
  localparam logic [2:0] SZ_LB  = 3'b000;
  localparam logic [2:0] SZ_LBU = 3'b001;
  localparam logic [2:0] SZ_LH  = 3'b010;
  localparam logic [2:0] SZ_LHU = 3'b011;
  localparam logic [2:0] SZ_W   = 3'b100;
  localparam logic [2:0] SZ_SB  = 3'b101;
  localparam logic [2:0] SZ_SH  = 3'b110;

endpackage

// File: rtl/mips_ls_sequencer_if.sv
// rtl/mips_ls_sequencer_if.sv - instruction handshake, memory handshake and control strobes
// Counter signals exist only when MIPS_LS_PERF_EN is defined.
interface mips_ls_sequencer_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        mem_ready;
  logic [31:0] ir;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        lui_signal;
  logic [2:0]  size_sel;
  logic        busy;
  logic        illegal_op;
  logic        mem_err;
`ifdef MIPS_LS_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  modport master (
    output instr_valid, instruction, mem_ready,
    input  instr_ready, ir, reg_write, mem_read, mem_write, lui_signal,
           size_sel, busy, illegal_op, mem_err
`ifdef MIPS_LS_PERF_EN
           , retired_cnt, stall_cnt
`endif
  );

  modport slave (
    input  instr_valid, instruction, mem_ready,
    output instr_ready, ir, reg_write, mem_read, mem_write, lui_signal,
           size_sel, busy, illegal_op, mem_err
`ifdef MIPS_LS_PERF_EN
           , retired_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/mips_ls_decode.sv
// rtl/mips_ls_decode.sv - opcode classification and size_sel lookup
// Purely combinational; also reused by the datapath for the extension muxes.
module mips_ls_decode
  import mips_ls_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_lui_o,
  output logic       illegal_o,
  output logic [2:0] size_sel_o
);

  always_comb begin
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    is_lui_o   = 1'b0;
    illegal_o  = 1'b0;
    size_sel_o = SZ_LB;
    case (opcode_i)
      OP_LB:  begin is_load_o  = 1'b1; size_sel_o = SZ_LB;  end
      OP_LBU: begin is_load_o  = 1'b1; size_sel_o = SZ_LBU; end
      OP_LH:  begin is_load_o  = 1'b1; size_sel_o = SZ_LH;  end
      OP_LHU: begin is_load_o  = 1'b1; size_sel_o = SZ_LHU; end
      OP_LW:  begin is_load_o  = 1'b1; size_sel_o = SZ_W;   end
      OP_SW:  begin is_store_o = 1'b1; size_sel_o = SZ_W;   end
      OP_SB:  begin is_store_o = 1'b1; size_sel_o = SZ_SB;  end
      OP_SH:  begin is_store_o = 1'b1; size_sel_o = SZ_SH;  end
      OP_LUI: is_lui_o  = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_ls_sequencer.sv
// rtl/mips_ls_sequencer.sv - multi-cycle IDLE/DECODE/ADDR/MEM/WB control for loads, stores and lui
// Define MIPS_LS_PERF_EN to add retired_cnt/stall_cnt.
module mips_ls_sequencer
  import mips_ls_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  mips_ls_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_DECODE = DECODE;
  localparam logic [2:0] S_ADDR   = ADDR;
  localparam logic [2:0] S_MEM    = MEM;
  localparam logic [2:0] S_WB     = WB;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  logic [2:0]        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;

  logic       is_load;
  logic       is_store;
  logic       is_lui;
  logic       illegal;
  logic [2:0] size_sel;

  mips_ls_decode u_decode (
    .opcode_i   (ir_q[31:26]),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .is_lui_o   (is_lui),
    .illegal_o  (illegal),
    .size_sel_o (size_sel)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    illegal_d = 1'b0;
    mem_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_lui) begin
          state_d = S_WB;
        end else if (is_load || is_store) begin
          state_d = S_ADDR;
        end else begin
          state_d   = S_IDLE;
          illegal_d = illegal;
        end
      end
      S_ADDR: begin
        state_d = S_MEM;
        wait_d  = '0;
      end
      S_MEM: begin
        // a completion in the limit cycle wins over the timeout
        if (bus.mem_ready) begin
          state_d = is_load ? S_WB : S_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_IDLE;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  // strobes depend on state and IR only, so reset clears them without a clock
  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.ir          = ir_q;
  assign bus.reg_write   = (state_q == S_WB);
  assign bus.lui_signal  = (state_q == S_WB) && is_lui;
  assign bus.mem_read    = (state_q == S_MEM) && is_load;
  assign bus.mem_write   = (state_q == S_MEM) && is_store;
  assign bus.size_sel    = (state_q == S_IDLE) ? 3'b000 : size_sel;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_err     = mem_err_q;

`ifdef MIPS_LS_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;
  logic        retire;
  logic        stall;

  assign retire = (state_q == S_WB) || ((state_q == S_MEM) && is_store && bus.mem_ready);
  assign stall  = (state_q == S_MEM) && !bus.mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire) retired_q <= retired_q + 32'd1;
      if (stall)  stall_q   <= stall_q + 32'd1;
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_mips_ls_sequencer.sv
// tb/tb_mips_ls_sequencer.sv - scoreboard bench for mips_ls_sequencer
module tb_mips_ls_sequencer;

  localparam int WAIT_MAX = 15;
  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_LUI = 2;
  localparam int K_ILL = 3;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       rw;
    logic       mrd;
    logic       mwr;
    logic       lui;
    logic [2:0] sz;
    logic       ill;
    logic       err;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mips_ls_sequencer_if bus ();

  mips_ls_sequencer #(.WAIT_MAX(WAIT_MAX), .WAIT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];
  logic pend_ill = 1'b0;
  logic pend_err = 1'b0;
`ifdef MIPS_LS_PERF_EN
  int exp_retired = 0;
  int exp_stall   = 0;
`endif

  function automatic obs_t mk(input logic rdy, input logic busy, input logic rw, input logic mrd,
                              input logic mwr, input logic lui, input logic [2:0] sz,
                              input logic ill, input logic err);
    obs_t o;
    o = '{rdy, busy, rw, mrd, mwr, lui, sz, ill, err};
    return o;
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o = '{bus.instr_ready, bus.busy, bus.reg_write, bus.mem_read, bus.mem_write,
          bus.lui_signal, bus.size_sel, bus.illegal_op, bus.mem_err};
    return o;
  endfunction

  function automatic void classify(input logic [31:0] ins, output int kind, output logic [2:0] sz);
    sz = 3'b000;
    case (ins[31:26])
      6'h20: begin kind = K_LD; sz = 3'b000; end
      6'h24: begin kind = K_LD; sz = 3'b001; end
      6'h21: begin kind = K_LD; sz = 3'b010; end
      6'h25: begin kind = K_LD; sz = 3'b011; end
      6'h23: begin kind = K_LD; sz = 3'b100; end
      6'h2B: begin kind = K_ST; sz = 3'b100; end
      6'h28: begin kind = K_ST; sz = 3'b101; end
      6'h29: begin kind = K_ST; sz = 3'b110; end
      6'h0F: kind = K_LUI;
      default: kind = K_ILL;
    endcase
  endfunction

  // one clock cycle: drive this cycle's inputs, queue the expected outputs, compare at negedge
  task automatic cyc(input logic v, input logic [31:0] ins, input logic mr, input obs_t e,
                     input string nm);
    obs_t got;
    obs_t want;
    @(posedge clock);
    #1;
    bus.instr_valid = v;
    bus.instruction = ins;
    bus.mem_ready   = mr;
    exp_q.push_back(e);
    @(negedge clock);
    got  = actual();
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got rdy/busy/rw/mrd/mwr/lui/sz/ill/err=%b required %b", nm, got, want);
    end
  endtask

  task automatic idle_cyc(input string nm);
    cyc(1'b0, 32'h0, 1'b1, mk(1, 0, 0, 0, 0, 0, 3'b000, pend_ill, pend_err), nm);
    pend_ill = 1'b0;
    pend_err = 1'b0;
  endtask

  // n_wait: MEM cycles with mem_ready low before it rises; >= WAIT_MAX means timeout
  task automatic run_instr(input logic [31:0] ins, input int n_wait, input string nm);
    int         kind;
    logic [2:0] sz;
    logic       mr;
    logic       done;
    classify(ins, kind, sz);
    cyc(1'b1, ins, 1'b1, mk(1, 0, 0, 0, 0, 0, 3'b000, pend_ill, pend_err), {nm, "_accept"});
    pend_ill = 1'b0;
    pend_err = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, mk(0, 1, 0, 0, 0, 0, sz, 0, 0), {nm, "_decode"});
    total++;
    if (bus.ir !== ins) begin
      bad++;
      $display("FAIL %s_ir: got %h required %h", nm, bus.ir, ins);
    end
    if (kind == K_ILL) begin
      pend_ill = 1'b1;
      return;
    end
    if (kind == K_LUI) begin
      cyc(1'b0, 32'h0, 1'b1, mk(0, 1, 1, 0, 0, 1, sz, 0, 0), {nm, "_wb"});
`ifdef MIPS_LS_PERF_EN
      exp_retired++;
`endif
      return;
    end
    cyc(1'b0, 32'h0, 1'b1, mk(0, 1, 0, 0, 0, 0, sz, 0, 0), {nm, "_addr"});
    done = 1'b0;
    for (int i = 0; i < WAIT_MAX && !done; i++) begin
      mr = (i >= n_wait);
      cyc(1'b0, 32'h0, mr, mk(0, 1, 0, kind == K_LD, kind == K_ST, 0, sz, 0, 0), {nm, "_mem"});
      if (mr) done = 1'b1;
`ifdef MIPS_LS_PERF_EN
      else exp_stall++;
`endif
    end
    if (!done) begin
      pend_err = 1'b1;
      return;
    end
`ifdef MIPS_LS_PERF_EN
    exp_retired++;
`endif
    if (kind == K_ST) return;
    cyc(1'b0, 32'h0, 1'b1, mk(0, 1, 1, 0, 0, 0, sz, 0, 0), {nm, "_wb"});
  endtask

  task automatic test_reset();
    obs_t got;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'h0;
    bus.mem_ready   = 1'b0;
    repeat (2) @(negedge clock);
    got = actual();
    total++;
    if (got !== mk(1, 0, 0, 0, 0, 0, 3'b000, 0, 0)) begin
      bad++;
      $display("FAIL reset_outputs: got %b required %b", got, mk(1, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    end
    total++;
    if (bus.ir !== 32'h0) begin
      bad++;
      $display("FAIL reset_ir: got %h required 00000000", bus.ir);
    end
    reset = 1'b0;
    idle_cyc("reset_idle");
  endtask

  task automatic test_lw();
    run_instr(32'h8C220004, 0, "lw");
    idle_cyc("lw_done");
  endtask

  task automatic test_sb_wait();
    run_instr(32'hA0000000, 3, "sb_wait");
    idle_cyc("sb_done");
  endtask

  task automatic test_lui();
    run_instr(32'h3C011234, 0, "lui");
    idle_cyc("lui_done");
  endtask

  task automatic test_illegal();
    run_instr(32'hFC000000, 0, "illegal");
    idle_cyc("illegal_pulse");
    idle_cyc("illegal_clear");
  endtask

  task automatic test_timeout();
    run_instr(32'h94000000, WAIT_MAX, "lhu_timeout");
    idle_cyc("timeout_pulse");
    idle_cyc("timeout_clear");
  endtask

  task automatic test_ready_at_limit();
    run_instr(32'h84000000, WAIT_MAX - 1, "lh_limit");
    idle_cyc("limit_no_err");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [11];
    ops = '{6'h23, 6'h2B, 6'h24, 6'h20, 6'h0F, 6'h21, 6'h3F, 6'h29, 6'h25, 6'h28, 6'h00};
    for (int i = 0; i < 11; i++)
      run_instr({ops[i], 26'($urandom())}, int'($urandom_range(0, 3)), "b2b");
    idle_cyc("b2b_done");
  endtask

`ifdef MIPS_LS_PERF_EN
  task automatic test_perf();
    total++;
    if (bus.retired_cnt !== 32'(exp_retired)) begin
      bad++;
      $display("FAIL perf_retired: got %0d required %0d", bus.retired_cnt, exp_retired);
    end
    total++;
    if (bus.stall_cnt !== 32'(exp_stall)) begin
      bad++;
      $display("FAIL perf_stall: got %0d required %0d", bus.stall_cnt, exp_stall);
    end
  endtask
`endif

  task automatic test_reset_mid_mem();
    obs_t got;
    cyc(1'b1, 32'hA0000000, 1'b1, mk(1, 0, 0, 0, 0, 0, 3'b000, pend_ill, pend_err), "rst_accept");
    pend_ill = 1'b0;
    pend_err = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, mk(0, 1, 0, 0, 0, 0, 3'b101, 0, 0), "rst_decode");
    cyc(1'b0, 32'h0, 1'b0, mk(0, 1, 0, 0, 0, 0, 3'b101, 0, 0), "rst_addr");
    cyc(1'b0, 32'h0, 1'b0, mk(0, 1, 0, 0, 1, 0, 3'b101, 0, 0), "rst_mem");
    #2;
    reset = 1'b1;
    #1;
    got = actual();
    total++;
    if (got !== mk(1, 0, 0, 0, 0, 0, 3'b000, 0, 0)) begin
      bad++;
      $display("FAIL rst_async_drop: got %b required %b", got, mk(1, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    end
    @(negedge clock);
    reset = 1'b0;
`ifdef MIPS_LS_PERF_EN
    exp_retired = 0;
    exp_stall   = 0;
`endif
    total++;
    if (bus.busy !== 1'b0 || bus.ir !== 32'h0) begin
      bad++;
      $display("FAIL rst_release: got busy=%b ir=%h required busy=0 ir=00000000", bus.busy, bus.ir);
    end
    idle_cyc("rst_idle");
    run_instr(32'h8C010008, 1, "lw_after_rst");
    idle_cyc("lw_after_rst_done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sb_wait();
    test_lui();
    test_illegal();
    test_timeout();
    test_ready_at_limit();
    test_back_to_back();
`ifdef MIPS_LS_PERF_EN
    test_perf();
`endif
    test_reset_mid_mem();
`ifdef MIPS_LS_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_ls_sequencer.md
Name: mips_ls_sequencer

Overview:
Multi-cycle control sequencer for the MIPS load/store datapath: register file, 32-bit ALU, data memory, and the lb/lbu/lh/lhu extension units.
- Accepts one instruction at a time over a valid/ready handshake and latches it into an instruction register (IR).
- Steps through decode, address, memory and writeback phases.
- Drives RegWrite, MemRead, MemWrite, the lui select and the 3-bit memory size select.
- Memory access uses a ready handshake, guarded by a bounded wait timeout.

Parameters:
WAIT_MAX, 15, maximum cycles spent in MEM waiting for mem_ready before abort (1..255).
WAIT_W, 8, width of the wait counter; must satisfy 2**WAIT_W > WAIT_MAX.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
instr_valid  input  1  instruction word present.
instr_ready  output  1  sequencer can accept an instruction.
instruction  input  32  instruction word; opcode in [31:26].
mem_ready  input  1  data memory has completed the current access.
ir  output  32  latched instruction; feeds register addresses and the immediate.
reg_write  output  1  register file write enable.
mem_read  output  1  data memory read strobe.
mem_write  output  1  data memory write strobe.
lui_signal  output  1  selects the lui immediate path for write data.
size_sel  output  3  {select2,select1,select0}: 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw/sw, 101 sb, 110 sh.
busy  output  1  high in every state except IDLE.
illegal_op  output  1  one-cycle pulse: unsupported opcode dropped.
mem_err  output  1  one-cycle pulse: memory timeout abort.

Behaviour:
- Opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B, lui 0x0F. Every other opcode is illegal.
- Reset values: state=IDLE, ir=0, wait counter=0, illegal_op=0, mem_err=0. All strobes and busy are 0; instr_ready is 1.
- Handshake: instr_ready = (state==IDLE), combinational from state only. On instr_valid&&instr_ready the IR loads and state goes to DECODE.
- Strobes are decoded only from the state register and the IR; there is no combinational input-to-output path.
- FSM states: IDLE, DECODE, ADDR, MEM, WB.
- DECODE:
  - lui -> WB.
  - load or store -> ADDR.
  - illegal -> IDLE, with illegal_op pulsed on the next cycle.
- ADDR: one cycle for the ALU address to settle; always -> MEM. The wait counter clears on entry to MEM.
- MEM:
  - mem_read=1 for loads, mem_write=1 for stores; size_sel valid throughout.
  - If mem_ready: loads -> WB, stores -> IDLE.
  - Otherwise the counter increments. When counter==WAIT_MAX-1 without mem_ready: -> IDLE, mem_err pulses, no register write.
- WB: reg_write=1 for exactly one cycle; lui_signal=1 in WB for lui only; -> IDLE.
- size_sel is driven from the IR in every non-IDLE state and is 000 in IDLE.
- Latency, accept cycle to return to IDLE, with zero-wait memory:
  - lui: 3 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
- mem_ready outside MEM is ignored.
- mem_ready in the same cycle as the timeout limit: the access completes and there is no mem_err.
- A reset in any state aborts immediately: strobes drop asynchronously and no partial write is issued.
- Back-to-back operation: a new instruction may be accepted in the IDLE cycle immediately after WB.

Optional Feature:
- MIPS_LS_PERF_EN defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - retired_cnt increments on each WB exit and each completed store.
  - stall_cnt increments on each MEM cycle without mem_ready.
  - Both counters wrap at 2**32.
- Undefined: neither port nor logic exists; all other behaviour is identical.

Decomposition:
- Shared package mips_ls_pkg holds:
  - opcode localparams (OP_LB ... OP_LUI);
  - state enum (IDLE, DECODE, ADDR, MEM, WB);
  - size_sel encodings SZ_LB ... SZ_SH.
- One natural sub-module, mips_ls_decode: combinational mapping from opcode to is_load, is_store, is_lui, illegal and size_sel. It is shared with the top-level datapath.

Test Plan:
- Zero-wait lw, instruction 0x8C220004, mem_ready tied to 1 -> mem_read high for exactly 1 cycle; size_sel=100; reg_write pulses 4 cycles after acceptance; instr_ready back 5 cycles after acceptance.
- sb, opcode 0x28, with mem_ready delayed 3 cycles -> mem_write held 4 cycles; size_sel=101; reg_write never asserted.
- lui, opcode 0x0F -> no mem strobes; lui_signal and reg_write both high in the same single WB cycle.
- Illegal opcode 0x3F -> illegal_op pulses once; no strobes; instr_ready returns after 2 cycles.
- lhu with mem_ready held 0 and WAIT_MAX=15 -> mem_read high 15 cycles, then mem_err pulses, no reg_write, FSM in IDLE.
- reset asserted mid-MEM of a store -> mem_write drops in the same cycle with no clock edge; after release, busy=0 and ir=0.
